// File: rtl/sponge_pkg.sv
// Shared types and padding constants for the sponge absorb/squeeze blocks.
package sponge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      PAD,
      PERM,
      PWAIT,
      DONE
   } absorb_state_t;

   localparam logic [7:0] PAD_FIRST = 8'h01;
   localparam logic [7:0] PAD_LAST  = 8'h80;

endpackage

// File: rtl/sponge_absorb_if.sv
// Message word stream into the absorb block (valid/ready with last-word byte count).
interface sponge_absorb_if #(
   parameter int RWIDTH = 32,
   parameter int BW     = $clog2(RWIDTH/8 + 1)
);
   logic [RWIDTH-1:0] msg_data;
   logic              msg_valid;
   logic              msg_ready;
   logic              msg_last;
   logic [BW-1:0]     msg_bytes;

   modport master (output msg_data, msg_valid, msg_last, msg_bytes, input msg_ready);
   modport slave  (input msg_data, msg_valid, msg_last, msg_bytes, output msg_ready);
endinterface

// File: rtl/sponge_pad.sv
// pad10*1 on one rate word: masks bytes past the message end and inserts the 0x01/0x80 markers.
module sponge_pad
   import sponge_pkg::*;
#(
   parameter int RWIDTH = 32,
   parameter int BW     = $clog2(RWIDTH/8 + 1)
) (
   input  logic [RWIDTH-1:0] data,
   input  logic [BW-1:0]     bytes,
   input  logic              last,
   input  logic              pad_only,
   output logic [RWIDTH-1:0] padded
);

   localparam int unsigned   NB   = RWIDTH / 8;
   localparam logic [BW-1:0] NB_B = BW'(NB);

   logic [BW-1:0] b;

   always_comb begin
      b      = (bytes > NB_B) ? NB_B : bytes;
      padded = data;
      if (pad_only) begin
         padded        = '0;
         padded[7:0]   = PAD_FIRST;
         padded[RWIDTH-1 -: 8] = padded[RWIDTH-1 -: 8] ^ PAD_LAST;
      end else if (last && (b != NB_B)) begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (k >= 32'(b)) padded[8*k +: 8] = 8'h00;
            if (k == 32'(b)) padded[8*k +: 8] = padded[8*k +: 8] ^ PAD_FIRST;
         end
         // XOR (not assign) so a single remaining byte becomes 0x81
         padded[RWIDTH-1 -: 8] = padded[RWIDTH-1 -: 8] ^ PAD_LAST;
      end
   end

endmodule

// File: rtl/sponge_absorb.sv
// Sponge absorb phase: XORs padded message words into the rate and runs the
// external permutation after every block, handing the final state to squeeze.
module sponge_absorb
   import sponge_pkg::*;
#(
   parameter int CWIDTH    = 320,
   parameter int RWIDTH    = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CWIDTH-1:0]    state_in,
   sponge_absorb_if.slave       msg,
   output logic                 perm_start,
   output logic [CWIDTH-1:0]    perm_state_o,
   input  logic [CWIDTH-1:0]    perm_state_i,
   input  logic                 perm_done,
   output logic [CWIDTH-1:0]    state_out,
   output logic                 done,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] blk_cnt
);

   localparam int unsigned   NB   = RWIDTH / 8;
   localparam int            BW   = $clog2(NB + 1);
   localparam logic [BW-1:0] NB_B = BW'(NB);

   absorb_state_t     st;
   logic [CWIDTH-1:0] state;
   logic              pad_pending;
   logic              final_blk;
   logic [RWIDTH-1:0] padded;

   sponge_pad #(.RWIDTH(RWIDTH), .BW(BW)) u_pad (
      .data     (msg.msg_data),
      .bytes    (msg.msg_bytes),
      .last     (msg.msg_last),
      .pad_only (st == PAD),
      .padded   (padded)
   );

   assign msg.msg_ready = (st == ACCEPT);
   assign perm_state_o  = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= IDLE;
         state       <= '0;
         state_out   <= '0;
         perm_start  <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         blk_cnt     <= '0;
         pad_pending <= 1'b0;
         final_blk   <= 1'b0;
      end else begin
         perm_start <= 1'b0;
         done       <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  state       <= state_in;
                  blk_cnt     <= '0;
                  busy        <= 1'b1;
                  pad_pending <= 1'b0;
                  final_blk   <= 1'b0;
                  st          <= ACCEPT;
               end
            end
            ACCEPT: begin
               if (msg.msg_valid) begin
                  state[RWIDTH-1:0] <= state[RWIDTH-1:0] ^ padded;
                  if (msg.msg_last) begin
                     if (msg.msg_bytes >= NB_B) pad_pending <= 1'b1;
                     else                       final_blk   <= 1'b1;
                  end
                  perm_start <= 1'b1;
                  st         <= PERM;
               end
            end
            PAD: begin
               state[RWIDTH-1:0] <= state[RWIDTH-1:0] ^ padded;
               pad_pending       <= 1'b0;
               final_blk         <= 1'b1;
               perm_start        <= 1'b1;
               st                <= PERM;
            end
            PERM: begin
               if (blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
               st <= PWAIT;
            end
            PWAIT: begin
               if (perm_done) begin
                  state <= perm_state_i;
                  // done/state_out are registered on entry so they appear one cycle after perm_done
                  if (final_blk) begin
                     state_out <= perm_state_i;
                     done      <= 1'b1;
                     st        <= DONE;
                  end else if (pad_pending) begin
                     st <= PAD;
                  end else begin
                     st <= ACCEPT;
                  end
               end
            end
            DONE: begin
               busy      <= 1'b0;
               final_blk <= 1'b0;
               st        <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sponge_absorb.sv
// Scoreboard bench for sponge_absorb with a rotl-by-1, 3-cycle permutation model.
module tb_sponge_absorb;
   import sponge_pkg::*;

   localparam int CW = 320;
   localparam int RW = 32;
   localparam int CN = 16;

   typedef struct {
      logic [CW-1:0] s;
      logic [CN-1:0] n;
   } done_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] state_in = '0;
   logic          perm_start;
   logic [CW-1:0] perm_state_o;
   logic [CW-1:0] perm_state_i = '0;
   logic          perm_done = 1'b0;
   logic [CW-1:0] state_out;
   logic          done;
   logic          busy;
   logic [CN-1:0] blk_cnt;
   logic          glitch_req = 1'b0;

   logic [CW-1:0] perm_q[$];
   done_t         done_q[$];
   int            total = 0;
   int            bad = 0;

   sponge_absorb_if #(.RWIDTH(RW)) m ();

   sponge_absorb #(.CWIDTH(CW), .RWIDTH(RW), .CNT_WIDTH(CN)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .state_in     (state_in),
      .msg          (m),
      .perm_start   (perm_start),
      .perm_state_o (perm_state_o),
      .perm_state_i (perm_state_i),
      .perm_done    (perm_done),
      .state_out    (state_out),
      .done         (done),
      .busy         (busy),
      .blk_cnt      (blk_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] rotl1(input logic [CW-1:0] s);
      return {s[CW-2:0], s[CW-1]};
   endfunction

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference absorb: XOR each (already padded) block into the rate, then permute.
   task automatic expect_blocks(input logic [CW-1:0] iv, input int n,
                                input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3,
                                input bit with_done);
      logic [CW-1:0] s;
      logic [31:0]   b[4];
      done_t         d;
      s = iv;
      b = '{b0, b1, b2, b3};
      for (int i = 0; i < n; i++) begin
         s[31:0] = s[31:0] ^ b[i];
         perm_q.push_back(s);
         s = rotl1(s);
      end
      if (with_done) begin
         d.s = s;
         d.n = CN'(n);
         done_q.push_back(d);
      end
   endtask

   task automatic do_start(input logic [CW-1:0] iv);
      start    = 1'b1;
      state_in = iv;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
      int t;
      t = 0;
      m.msg_data  = d;
      m.msg_last  = l;
      m.msg_bytes = nb;
      m.msg_valid = 1'b1;
      while (!m.msg_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", CW'(t < 200), CW'(1));
      @(negedge clk);
   endtask

   task automatic finish_msg();
      int t;
      t = 0;
      m.msg_valid = 1'b0;
      while (!done && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("done_wait", CW'(t < 200), CW'(1));
      @(negedge clk);
      check("perm_q_left", CW'(perm_q.size()), '0);
      check("done_q_left", CW'(done_q.size()), '0);
      check("busy_after", CW'(busy), '0);
   endtask

   initial begin : perm_model
      int            cnt;
      logic [CW-1:0] cap;
      cnt = 0;
      cap = '0;
      forever begin
         @(negedge clk);
         perm_done = 1'b0;
         if (reset) begin
            cnt = 0;
         end else begin
            if (cnt != 0) begin
               cnt--;
               if (cnt == 0) begin
                  perm_done    = 1'b1;
                  perm_state_i = rotl1(cap);
               end
            end
            if (perm_start) begin
               cnt = 3;
               cap = perm_state_o;
            end
            if (glitch_req) begin
               perm_done    = 1'b1;
               perm_state_i = {10{32'hDEAD0BAD}};
            end
         end
      end
   end

   initial begin : monitor
      done_t e;
      forever begin
         @(negedge clk);
         if (perm_start) begin
            check("perm_pending", CW'(perm_q.size() != 0), CW'(1));
            check("ready_in_perm", CW'(m.msg_ready), '0);
            if (perm_q.size() != 0) check("perm_state", perm_state_o, perm_q.pop_front());
         end
         if (done) begin
            check("done_pending", CW'(done_q.size() != 0), CW'(1));
            if (done_q.size() != 0) begin
               e = done_q.pop_front();
               check("state_out", state_out, e.s);
               check("blk_cnt", CW'(blk_cnt), CW'(e.n));
            end
         end
      end
   end

   initial begin : stim
      m.msg_valid = 1'b0;
      m.msg_data  = '0;
      m.msg_last  = 1'b0;
      m.msg_bytes = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", CW'(busy), '0);
      check("rst_done", CW'(done), '0);
      check("rst_pstart", CW'(perm_start), '0);
      check("rst_state_out", state_out, '0);
      reset = 1'b0;
      @(negedge clk);

      // reset while waiting on the permutation
      expect_blocks('0, 1, 32'h00000055, 0, 0, 0, 1'b0);
      do_start('0);
      send_word(32'h00000055, 1'b1, 3'd4);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", CW'(busy), '0);
      check("mid_rst_blk", CW'(blk_cnt), '0);
      check("mid_rst_pstate", perm_state_o, '0);
      check("mid_rst_ready", CW'(m.msg_ready), '0);
      check("mid_rst_pstart", CW'(perm_start), '0);
      perm_q.delete();
      done_q.delete();
      @(negedge clk);
      reset = 1'b0;
      m.msg_valid = 1'b0;
      repeat (12) @(negedge clk);
      check("post_rst_busy", CW'(busy), '0);

      // partial final word, 2 bytes
      expect_blocks('0, 1, 32'h8001CCDD, 0, 0, 0, 1'b1);
      do_start('0);
      send_word(32'hAABBCCDD, 1'b1, 3'd2);
      finish_msg();

      // full final word needs a separate pad block
      expect_blocks('0, 2, 32'h11223344, 32'h80000001, 0, 0, 1'b1);
      do_start('0);
      send_word(32'h11223344, 1'b1, 3'd4);
      finish_msg();

      // empty message
      expect_blocks('0, 1, 32'h80000001, 0, 0, 0, 1'b1);
      do_start('0);
      send_word(32'h0, 1'b1, 3'd0);
      finish_msg();

      // back-to-back words with valid held high
      expect_blocks('0, 4, 32'h1, 32'h2, 32'h3, 32'h80000001, 1'b1);
      do_start('0);
      send_word(32'h1, 1'b0, 3'd0);
      send_word(32'h2, 1'b0, 3'd0);
      send_word(32'h3, 1'b1, 3'd4);
      finish_msg();

      // 3 of 4 bytes: shared 0x81 byte, nonzero IV
      expect_blocks({10{32'h13579BDF}}, 1, 32'h81ADBEEF, 0, 0, 0, 1'b1);
      do_start({10{32'h13579BDF}});
      send_word(32'hDEADBEEF, 1'b1, 3'd3);
      finish_msg();

      // byte count above NB is clamped to NB
      expect_blocks({10{32'h2468ACE0}}, 2, 32'h12345678, 32'h80000001, 0, 0, 1'b1);
      do_start({10{32'h2468ACE0}});
      send_word(32'h12345678, 1'b1, 3'd7);
      finish_msg();

      // single valid byte
      expect_blocks('0, 1, 32'h8000010D, 0, 0, 0, 1'b1);
      do_start('0);
      send_word(32'hCAFEF00D, 1'b1, 3'd1);
      finish_msg();

      // stray perm_done in ACCEPT and start during PWAIT are ignored
      expect_blocks({10{32'h0F0F1234}}, 2, 32'hA5A5A5A5, 32'h81C0FFEE, 0, 0, 1'b1);
      do_start({10{32'h0F0F1234}});
      #1 glitch_req = 1'b1;
      @(negedge clk);
      #1 glitch_req = 1'b0;
      send_word(32'hA5A5A5A5, 1'b0, 3'd0);
      m.msg_valid = 1'b0;
      @(negedge clk);
      do_start({10{32'hFFFF0000}});
      send_word(32'h00C0FFEE, 1'b1, 3'd3);
      finish_msg();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
